// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher constants, FSM states and GF(2^8) helpers.
// Used by aes_inv_cipher (optional AES_INV_CIPHER_ZEROIZE_EN) and aes_inv_sbox.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // General product, used for the field inverse inside the S-box.
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = gmul(a, a);
    r = p;
    for (int i = 0; i < 6; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] v
  );
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127-8*(4*c+r) -: 8] = v[127-8*src -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] v
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] =
        gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      o[119-32*c -: 8] =
        gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      o[111-32*c -: 8] =
        gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3);
      o[103-32*c -: 8] =
        gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box.
// Inverse affine map followed by the GF(2^8) multiplicative inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] t;

  // Undo the affine transform, then invert in the field.
  always_comb begin
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y = gf_inv(t);
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Option: AES_INV_CIPHER_ZEROIZE_EN hides round state and clears st on output.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);

  state_t       state, next;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] shifted;
  logic [127:0] sub;
  logic [127:0] t;
  logic [127:0] mixed;

  // Round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    shifted = inv_shift_rows(st);
    t       = sub ^ rk;
    mixed   = inv_mix_columns(t);
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a (shifted[127-8*i -: 8]),
      .y (sub[127-8*i -: 8])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next state and key index.
  always_comb begin
    next   = state;
    rk_idx = 4'(NR);
    unique case (state)
      IDLE: begin
        if (in_valid) next = ROUND;
      end
      ROUND: begin
        rk_idx = rnd;
        if (rnd == 4'd0) next = DONE;
      end
      DONE: begin
        rk_idx = 4'd0;
        if (out_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Block state and round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= 4'd0;
      st  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= ct ^ rk;
            rnd <= 4'(NR - 1);
          end
        end
        ROUND: begin
          if (rnd != 4'd0) begin
            st  <= mixed;
            rnd <= rnd - 4'd1;
          end else begin
            st <= t;
          end
        end
        DONE: begin
`ifdef AES_INV_CIPHER_ZEROIZE_EN
          if (out_ready) st <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
`ifdef AES_INV_CIPHER_ZEROIZE_EN
    pt = out_valid ? st : '0;
`else
    pt = st;
`endif
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Testbench for aes_inv_cipher: table-based forward AES model and key schedule.
// Random blocks are encrypted by the model and must decrypt back to the plaintext.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct = '0;
  logic         in_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic [127:0] pt;

  logic [127:0] rks [0:10];
  logic [7:0]   sbox [256];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

  aes_inv_cipher #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
              ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]],
               sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++)
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] s;
    s = p ^ rks[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a[4*c]   = gm(2, b[4*c]) ^ gm(3, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+1] = b[4*c] ^ gm(2, b[4*c+1]) ^ gm(3, b[4*c+2]) ^ b[4*c+3];
          a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gm(2, b[4*c+2]) ^ gm(3, b[4*c+3]);
          a[4*c+3] = gm(3, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gm(2, b[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) a[i] = b[i];
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
      s = s ^ rks[r];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] c);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    ct = c;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 128'(in_ready), 128'd1);
    chk("rk_idx_idle", 128'(rk_idx), 128'd10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ct = rnd128();
  endtask

  // Starts right after the accept edge; ends at the negedge in DONE.
  task automatic rounds(input logic [127:0] exp);
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      chk("rk_idx_round", 128'(rk_idx), 128'(k));
      chk("ov_round", 128'(out_valid), 128'd0);
`ifdef AES_INV_CIPHER_ZEROIZE_EN
      chk("pt_hidden", pt, 128'd0);
`endif
      @(posedge clk);
    end
    @(negedge clk);
    chk("ov_done", 128'(out_valid), 128'd1);
    chk("pt_done", pt, exp);
    chk("rk_idx_done", 128'(rk_idx), 128'd0);
  endtask

  task automatic handshake(input logic [127:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_after", 128'(out_valid), 128'd0);
    chk("ir_after", 128'(in_ready), 128'd1);
`ifdef AES_INV_CIPHER_ZEROIZE_EN
    chk("pt_after", pt, 128'd0);
`else
    chk("pt_after", pt, exp);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p, c, p2, c2;
    int t0, t1, w;
    bit got;
    build_sbox();

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    chk("rst_pt", pt, 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(in_ready), 128'd1);

    // FIPS-197 C.1
    expand(C1_KEY);
    chk("key_sched_k10", rks[10], C1_K10);
    accept(C1_CT);
    rounds(C1_PT);
    handshake(C1_PT);

    // Zero key
    expand('0);
    accept(Z_CT);
    rounds('0);
    handshake('0);

    // Random keys and blocks
    for (int n = 0; n < 4; n++) begin
      expand(rnd128());
      p = rnd128();
      accept(enc(p));
      rounds(p);
      handshake(p);
    end

    // Backpressure in DONE with a new block waiting
    expand(C1_KEY);
    accept(C1_CT);
    rounds(C1_PT);
    p = rnd128();
    c = enc(p);
    in_valid = 1'b1;
    ct = c;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_pt", pt, C1_PT);
      chk("bp_ov", 128'(out_valid), 128'd1);
      chk("bp_ir", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ir", 128'(in_ready), 128'd1);
    chk("bp_idle_ov", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rounds(p);
    handshake(p);

    // Back-to-back
    p = rnd128();
    c = enc(p);
    p2 = rnd128();
    c2 = enc(p2);
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    ct = c;
    @(posedge clk);
    #1;
    t0 = cyc;
    ct = c2;
    got = 0;
    w = 0;
    while (w < 30) begin
      @(negedge clk);
      w++;
      if (out_valid) begin
        chk("b2b_pt1", pt, p);
        got = 1;
      end
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    t1 = cyc;
    in_valid = 1'b0;
    chk("b2b_seen1", 128'(got), 128'd1);
    chk("b2b_gap", 128'(t1 - t0), 128'd12);
    rounds(p2);
    handshake(p2);

    // Reset while rk_idx == 5
    accept(C1_CT);
    w = 0;
    @(negedge clk);
    while (rk_idx != 4'd5 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mid_reach5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ir", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("mid_ir", 128'(in_ready), 128'd1);
    chk("mid_ov", 128'(out_valid), 128'd0);
    chk("mid_rk_idx", 128'(rk_idx), 128'd10);
    chk("mid_pt", pt, 128'd0);
    accept(C1_CT);
    rounds(C1_PT);
    handshake(C1_PT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 inverse cipher. It takes one 128-bit ciphertext block and returns the plaintext after one round per clock. It sits on the decrypt path beside the forward round datapath. Round keys come from an external key store through a combinational index/key lookup, and the block contains no key expansion.

## Interface
Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  block can accept ciphertext; equals (fsm==IDLE) && !rst.
- ct  in  128  ciphertext, FIPS-197 byte order (byte 0 = ct[127:120], column c = ct[127-32c -: 32]).
- rk_idx  out  4  round-key index requested this cycle.
- rk  in  128  round key for rk_idx, valid combinationally in the same cycle; same byte order as ct.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer takes plaintext.
- pt  out  128  plaintext, same byte order.

## Operation
- FSM states: IDLE, ROUND, DONE. There is a 4-bit round counter `rnd` and a 128-bit state register `st`.
- IDLE:
  - rk_idx=NR.
  - On in_valid && in_ready: `st <= ct ^ rk`, `rnd <= NR-1`, go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - Let t = InvSubBytes(InvShiftRows(st)) ^ rk.
  - If rnd!=0: `st <= InvMixColumns(t)` and `rnd <= rnd-1`.
  - If rnd==0: `st <= t` and go to DONE.
- DONE:
  - rk_idx=0, out_valid=1, pt=st.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE; there is no accept-while-done.
- InvShiftRows: row r is rotated right by r byte positions.
- InvMixColumns uses GF(2^8) multiplication by 0e/0b/0d/09 with polynomial 0x11b. All arithmetic is byte-wise XOR; there are no carries.
- in_valid, ct and out_ready are sampled only at the handshake edge. ct may change after acceptance.
- Reset at any time, including mid-ROUND: next state is IDLE, rnd=0, out_valid=0, the in-flight block is discarded, and no output is produced for it.

## Timing
- Reset values: in_ready=0 while rst is high and 1 from the first cycle after rst falls. out_valid=0, rk_idx=NR (IDLE), st=0, pt=0.
- Latency: out_valid rises 10 clock edges after the accepting edge. The accept edge is T0, rounds run on edges T1..T10, and out_valid is high after T10.
- The rk_idx sequence per block is 10 (accept cycle), 9, 8, …, 0.
- pt and out_valid are held stable while out_valid && !out_ready.
- Throughput is one block per 12 cycles when in_valid and out_ready are both held high: accept, 10 rounds, 1 DONE cycle, then back to IDLE.
- rk → st is a single-cycle combinational path. The key store must have no registered read.

## Configuration
- AES_INV_CIPHER_ZEROIZE_EN defined:
  - On the output handshake edge, st is cleared to 0.
  - pt is forced to 0 whenever out_valid=0, so intermediate round state is never visible.
- Not defined:
  - st retains the last plaintext after the handshake.
  - pt = st in all states, so intermediate round values are visible.

## Structure
- Shared package aes_pkg holds:
  - the round count constant (NR=10);
  - the FSM state enum;
  - GF functions xtime, gmul9, gmul11, gmul13, gmul14;
  - the inv_shift_rows and inv_mix_columns functions on 128-bit vectors.
- Sub-module aes_inv_sbox: combinational 8-bit in, 8-bit out inverse S-box lookup, instantiated 16× by generate.

## Test plan
- FIPS-197 C.1 vector. Round keys come from the bench model of key 000102030405060708090a0b0c0d0e0f; the round-10 key is 13111d7fe3944a17f307a78b4d2b30c5.
  - Stimulus: ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: pt=00112233445566778899aabbccddeeff, out_valid exactly 10 edges after accept, rk_idx sequence 10..0.
- Zero key.
  - Stimulus: ct=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Response: pt=00000000000000000000000000000000.
- Backpressure.
  - Stimulus: out_ready held low 5 cycles in DONE while in_valid=1 with a new ct.
  - Response: pt stable, in_ready=0, new ct not accepted; accepted on the first IDLE cycle after the handshake.
- Back-to-back.
  - Stimulus: two ciphertexts with in_valid and out_ready held high.
  - Response: both decrypt correctly; accept edges are 12 cycles apart.
- Reset mid-operation.
  - Stimulus: rst pulsed for 1 cycle when rk_idx=5.
  - Response: out_valid=0 and in_ready=1 the cycle after rst falls; the next C.1 block decrypts correctly with no stale output.
- With AES_INV_CIPHER_ZEROIZE_EN defined.
  - Response: pt reads 0 during ROUND and 0 after the handshake.
- Without AES_INV_CIPHER_ZEROIZE_EN.
  - Response: pt retains 00112233445566778899aabbccddeeff after the handshake.
